// File: rtl/fpnew_result_boxer.sv
// fpnew_result_boxer
//   Output stage for the FMA result path. Each accepted result is classified,
//   optionally canonicalized to the quiet NaN, NaN-boxed to 64 bits and held
//   in a 2-entry skid buffer. The outputs come straight from the head entry's
//   flops, and in_ready_o comes only from buffer state.
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   flush_i       synchronous flush of both buffer entries
//   in_valid_i    upstream result valid
//   in_ready_o    stage can accept a result (no path from out_ready_i)
//   in_result_i   packed {sign, exponent, mantissa} in FpFormat
//   in_tag_i      sideband tag
//   out_valid_o   head entry valid
//   out_ready_i   consumer accepts the head entry
//   out_result_o  64-bit boxed result
//   out_class_o   {is_nan, is_snan, is_inf, is_zero} of the original input
//   out_tag_o     tag paired with out_result_o
//
// FpFormat follows the fpnew encoding:
//   0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT.
module fpnew_result_boxer #(
  parameter int unsigned FpFormat = 0,
  parameter logic        NanBox   = 1'b1,
  parameter logic        CanonNaN = 1'b1,
  parameter int unsigned TagWidth = 4,
  localparam int unsigned EXP_BITS = (FpFormat == 1) ? 11 :
                                     (FpFormat == 2) ? 5  :
                                     (FpFormat == 3) ? 5  :
                                     (FpFormat == 4) ? 8  : 8,
  localparam int unsigned MAN_BITS = (FpFormat == 1) ? 52 :
                                     (FpFormat == 2) ? 10 :
                                     (FpFormat == 3) ? 2  :
                                     (FpFormat == 4) ? 7  : 23,
  localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    in_result_i,
  input  logic [TagWidth-1:0] in_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [63:0]         out_result_o,
  output logic [3:0]          out_class_o,
  output logic [TagWidth-1:0] out_tag_o
);

  logic [EXP_BITS-1:0] exponent;
  logic [MAN_BITS-1:0] mantissa;
  logic                exp_ones, man_zero;
  logic                is_nan, is_snan, is_inf, is_zero;
  logic [3:0]          in_class;
  logic [WIDTH-1:0]    payload;
  logic [63:0]         in_boxed;

  assign exponent = in_result_i[WIDTH-2 -: EXP_BITS];
  assign mantissa = in_result_i[MAN_BITS-1:0];
  assign exp_ones = &exponent;
  assign man_zero = ~|mantissa;

  assign is_nan   = exp_ones & ~man_zero;
  assign is_snan  = is_nan & ~mantissa[MAN_BITS-1];
  assign is_inf   = exp_ones & man_zero;
  assign is_zero  = (exponent == '0) & man_zero;
  assign in_class = {is_nan, is_snan, is_inf, is_zero};

  // Canonical quiet NaN: positive sign, all-ones exponent, only the quiet bit set.
  localparam logic [WIDTH-1:0] CANON_QNAN =
      {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

  assign payload = (CanonNaN && is_nan) ? CANON_QNAN : in_result_i;

  // The boxed value is stored whole so that reset-cleared entries read as 0
  // even when NanBox would fill the upper bits with ones.
  if (WIDTH < 64) begin : g_box
    assign in_boxed = {{(64-WIDTH){NanBox}}, payload};
  end else begin : g_nobox
    assign in_boxed = payload;
  end

  logic                e0_valid, e1_valid;
  logic [63:0]         e0_result, e1_result;
  logic [3:0]          e0_class, e1_class;
  logic [TagWidth-1:0] e0_tag, e1_tag;
  logic                push, pop;

  assign in_ready_o   = ~e1_valid;
  assign out_valid_o  = e0_valid;
  assign out_result_o = e0_result;
  assign out_class_o  = e0_class;
  assign out_tag_o    = e0_tag;

  assign push = in_valid_i & in_ready_o;
  assign pop  = e0_valid & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e0_valid  <= 1'b0;
      e1_valid  <= 1'b0;
      e0_result <= '0;
      e1_result <= '0;
      e0_class  <= '0;
      e1_class  <= '0;
      e0_tag    <= '0;
      e1_tag    <= '0;
    end else if (flush_i) begin
      // Flush beats push; any pop this cycle was already seen by the consumer.
      e0_valid <= 1'b0;
      e1_valid <= 1'b0;
    end else if (e1_valid) begin
      // Full: no push can happen, only a shift down on pop.
      if (pop) begin
        e0_result <= e1_result;
        e0_class  <= e1_class;
        e0_tag    <= e1_tag;
        e1_valid  <= 1'b0;
      end
    end else if (e0_valid) begin
      if (push && pop) begin
        e0_result <= in_boxed;
        e0_class  <= in_class;
        e0_tag    <= in_tag_i;
      end else if (push) begin
        e1_result <= in_boxed;
        e1_class  <= in_class;
        e1_tag    <= in_tag_i;
        e1_valid  <= 1'b1;
      end else if (pop) begin
        e0_valid <= 1'b0;
      end
    end else if (push) begin
      e0_result <= in_boxed;
      e0_class  <= in_class;
      e0_tag    <= in_tag_i;
      e0_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpnew_result_boxer.sv
module tb_fpnew_result_boxer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in32;
  logic [63:0] in64;
  logic [3:0]  tag;

  logic        rdy_a, vld_a, rdy_c, vld_c, rdy_b, vld_b, rdy_d, vld_d;
  logic [63:0] res_a, res_c, res_b, res_d;
  logic [3:0]  cls_a, cls_c, cls_b, cls_d;
  logic [3:0]  tag_a, tag_c, tag_b, tag_d;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpnew_result_boxer dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_a), .in_result_i(in32), .in_tag_i(tag),
    .out_valid_o(vld_a), .out_ready_i(out_ready), .out_result_o(res_a),
    .out_class_o(cls_a), .out_tag_o(tag_a));

  fpnew_result_boxer #(.CanonNaN(1'b0)) dut_nc (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_c), .in_result_i(in32), .in_tag_i(tag),
    .out_valid_o(vld_c), .out_ready_i(out_ready), .out_result_o(res_c),
    .out_class_o(cls_c), .out_tag_o(tag_c));

  fpnew_result_boxer #(.NanBox(1'b0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_b), .in_result_i(in32), .in_tag_i(tag),
    .out_valid_o(vld_b), .out_ready_i(out_ready), .out_result_o(res_b),
    .out_class_o(cls_b), .out_tag_o(tag_b));

  fpnew_result_boxer #(.FpFormat(1)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy_d), .in_result_i(in64), .in_tag_i(tag),
    .out_valid_o(vld_d), .out_ready_i(out_ready), .out_result_o(res_d),
    .out_class_o(cls_d), .out_tag_o(tag_d));

  typedef struct {
    logic [31:0] in32;
    logic [63:0] in64;
    logic [3:0]  tag;
    logic [63:0] exp_def;
    logic [63:0] exp_nc;
    logic [63:0] exp_nb;
    logic [3:0]  cls32;
    logic [63:0] exp_64;
    logic [3:0]  cls64;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  cls;
    logic [3:0]  tag;
  } item_t;

  vec_t  vecs[7];
  item_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for the default FP32 instance, from the format definition.
  function automatic item_t ref32(input logic [31:0] v, input logic [3:0] t);
    item_t it;
    int unsigned e, m;
    bit nan, snan, inf, zero;
    e    = (v >> 23) & 32'hFF;
    m    = v & 32'h7FFFFF;
    nan  = (e == 255) && (m != 0);
    snan = nan && (m < 32'h400000);
    inf  = (e == 255) && (m == 0);
    zero = (e == 0) && (m == 0);
    it.res = {32'hFFFF_FFFF, nan ? 32'h7FC0_0000 : v};
    it.cls = {nan, snan, inf, zero};
    it.tag = t;
    return it;
  endfunction

  function automatic logic [31:0] rand_fp32();
    logic [31:0] s;
    s = {$urandom_range(1, 0), 31'b0};
    case ($urandom_range(5, 0))
      0: return s | 32'h7FC0_0000 | $urandom_range(32'h3FFFFF, 0);
      1: return s | 32'h7F80_0000 | $urandom_range(32'h3FFFFF, 1);
      2: return s | 32'h7F80_0000;
      3: return s;
      4: return s | $urandom_range(32'h7FFFFF, 1);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk_head(input string name, input logic [63:0] r, input logic [3:0] c,
                          input logic [3:0] t);
    chk({name, "_valid"}, {63'b0, vld_a}, 64'd1);
    chk({name, "_result"}, res_a, r);
    chk({name, "_class"}, {60'b0, cls_a}, {60'b0, c});
    chk({name, "_tag"}, {60'b0, tag_a}, {60'b0, t});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h7FC00000, 64'h7FF8000000000000, 4'd3,
                64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_7FC00000, 64'h00000000_7FC00000, 4'b1000,
                64'h7FF8000000000000, 4'b1000};
    vecs[1] = '{32'hFF800001, 64'h7FF0000000000001, 4'd5,
                64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_FF800001, 64'h00000000_7FC00000, 4'b1100,
                64'h7FF8000000000000, 4'b1100};
    vecs[2] = '{32'h7F800000, 64'hFFF0000000000000, 4'd7,
                64'hFFFFFFFF_7F800000, 64'hFFFFFFFF_7F800000, 64'h00000000_7F800000, 4'b0010,
                64'hFFF0000000000000, 4'b0010};
    vecs[3] = '{32'h80000000, 64'h0000000000000000, 4'd9,
                64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000, 64'h00000000_80000000, 4'b0001,
                64'h0000000000000000, 4'b0001};
    vecs[4] = '{32'h00000001, 64'h0000000000000001, 4'd10,
                64'hFFFFFFFF_00000001, 64'hFFFFFFFF_00000001, 64'h00000000_00000001, 4'b0000,
                64'h0000000000000001, 4'b0000};
    vecs[5] = '{32'h3F800000, 64'h3FF0000000000000, 4'd12,
                64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_3F800000, 64'h00000000_3F800000, 4'b0000,
                64'h3FF0000000000000, 4'b0000};
    vecs[6] = '{32'hFFC12345, 64'hFFF8123400000000, 4'd15,
                64'hFFFFFFFF_7FC00000, 64'hFFFFFFFF_FFC12345, 64'h00000000_7FC00000, 4'b1000,
                64'h7FF8000000000000, 4'b1000};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in32 = '0; in64 = '0; tag = '0;

    // Reset state, checked before any clock edge.
    #3;
    chk("rst_out_valid", {63'b0, vld_a}, 64'd0);
    chk("rst_in_ready", {63'b0, rdy_a}, 64'd1);
    chk("rst_out_result", res_a, 64'd0);
    chk("rst_out_class", {60'b0, cls_a}, 64'd0);
    chk("rst_out_tag", {60'b0, tag_a}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table vectors: one push per cycle with the consumer always ready.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in32 = vecs[i].in32; in64 = vecs[i].in64; tag = vecs[i].tag;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_def_valid", i), {63'b0, vld_a}, 64'd1);
      chk($sformatf("vec%0d_def_result", i), res_a, vecs[i].exp_def);
      chk($sformatf("vec%0d_def_class", i), {60'b0, cls_a}, {60'b0, vecs[i].cls32});
      chk($sformatf("vec%0d_def_tag", i), {60'b0, tag_a}, {60'b0, vecs[i].tag});
      chk($sformatf("vec%0d_nocanon_result", i), res_c, vecs[i].exp_nc);
      chk($sformatf("vec%0d_nocanon_class", i), {60'b0, cls_c}, {60'b0, vecs[i].cls32});
      chk($sformatf("vec%0d_nobox_result", i), res_b, vecs[i].exp_nb);
      chk($sformatf("vec%0d_fp64_result", i), res_d, vecs[i].exp_64);
      chk($sformatf("vec%0d_fp64_class", i), {60'b0, cls_d}, {60'b0, vecs[i].cls64});
    end
    tick();
    chk("drain_valid", {63'b0, vld_a}, 64'd0);

    // Backpressure: fill with A and B, C is refused, then all three drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1; in32 = 32'h3F800000; tag = 4'd1;
    tick();
    in32 = 32'h40000000; tag = 4'd2;
    tick();
    chk("bp_in_ready_full", {63'b0, rdy_a}, 64'd0);
    in32 = 32'h40400000; tag = 4'd4;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("bp_refuse_in_ready", {63'b0, rdy_a}, 64'd0);
      chk_head("bp_hold_a", 64'hFFFFFFFF_3F800000, 4'b0000, 4'd1);
    end
    out_ready = 1'b1;
    tick();
    chk_head("bp_b", 64'hFFFFFFFF_40000000, 4'b0000, 4'd2);
    chk("bp_in_ready_reopen", {63'b0, rdy_a}, 64'd1);
    tick();
    in_valid = 1'b0;
    chk_head("bp_c", 64'hFFFFFFFF_40400000, 4'b0000, 4'd4);
    tick();
    chk("bp_empty", {63'b0, vld_a}, 64'd0);

    // Flush with the buffer full and a push pending.
    out_ready = 1'b0;
    in_valid = 1'b1; in32 = 32'h11111111; tag = 4'd6;
    tick();
    in32 = 32'h22222222; tag = 4'd7;
    tick();
    in32 = 32'h33333333; tag = 4'd8; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {63'b0, vld_a}, 64'd0);
    chk("flush_in_ready", {63'b0, rdy_a}, 64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    chk("flush_c_dropped", {63'b0, vld_a}, 64'd0);

    // Async reset between edges with two entries buffered.
    out_ready = 1'b0;
    in_valid = 1'b1; in32 = 32'h44444444; tag = 4'd9;
    tick();
    in32 = 32'h55555555; tag = 4'd10;
    tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'b0, vld_a}, 64'd0);
    chk("arst_in_ready", {63'b0, rdy_a}, 64'd1);
    chk("arst_out_result", res_a, 64'd0);
    chk("arst_out_class", {60'b0, cls_a}, 64'd0);
    chk("arst_out_tag", {60'b0, tag_a}, 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in32 = 32'hFF800000; tag = 4'd11;
    tick();
    in_valid = 1'b0;
    chk_head("arst_fresh", 64'hFFFFFFFF_FF800000, 4'b0010, 4'd11);
    tick();

    // Randomized traffic on the default instance against a queue model.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit    p_ready, p_valid, do_push, do_pop;
      item_t it;
      chk("rnd_in_ready", {63'b0, rdy_a}, {63'b0, (q.size() < 2)});
      chk("rnd_out_valid", {63'b0, vld_a}, {63'b0, (q.size() > 0)});
      if (q.size() > 0) begin
        chk("rnd_result", res_a, q[0].res);
        chk("rnd_class", {60'b0, cls_a}, {60'b0, q[0].cls});
        chk("rnd_tag", {60'b0, tag_a}, {60'b0, q[0].tag});
      end
      p_valid   = ($urandom_range(9, 0) < 6);
      p_ready   = ($urandom_range(9, 0) < 6);
      in_valid  = p_valid;
      out_ready = p_ready;
      flush     = ($urandom_range(19, 0) == 0);
      in32      = rand_fp32();
      tag       = 4'($urandom);
      it        = ref32(in32, tag);
      do_push   = p_valid && (q.size() < 2);
      do_pop    = p_ready && (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(it);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
